// File: rtl/cpu_mem_lsu.sv
// cpu_mem_lsu -- load/store unit sitting between the EX and WB stages.
//
// Takes the EX-stage memory controls and address, drives a single-beat data
// memory bus (byte enables, lane-replicated store data), waits for the ack
// with a bounded timeout, extracts and extends load data, and registers the
// results into the MEM/WB pipeline registers (p_*).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_stall                global pipeline freeze
//   ex_c_*                   EX-stage controls (rfw, wbsource, drw, size, sext)
//   ex_alu_r                 access address
//   ex_rfb                   store data, ex_rt its source register
//   ex_rf_waddr, ex_jalra    passed through to the pipeline registers
//   wb_wdata                 WB-stage value used for store-data forwarding
//   dmem_*                   data memory bus (req/we/addr/be/data out, in/ack in)
//   mem_stall                this unit is waiting on the bus
//   p_*                      MEM/WB pipeline registers, p_berr flags a bus error
module cpu_mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_stall,
  input  logic                  ex_c_rfw,
  input  logic [1:0]            ex_c_wbsource,
  input  logic [1:0]            ex_c_drw,
  input  logic [1:0]            ex_c_size,
  input  logic                  ex_c_sext,
  input  logic [DATA_W-1:0]     ex_alu_r,
  input  logic [DATA_W-1:0]     ex_rfb,
  input  logic [REG_AW-1:0]     ex_rf_waddr,
  input  logic [REG_AW-1:0]     ex_rt,
  input  logic [DATA_W-1:0]     ex_jalra,
  input  logic [DATA_W-1:0]     wb_wdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W/8-1:0]   dmem_be,
  output logic [DATA_W-1:0]     dmem_data,
  input  logic [DATA_W-1:0]     dmem_in,
  input  logic                  dmem_ack,
  output logic                  mem_stall,
  output logic                  p_c_rfw,
  output logic [1:0]            p_c_wbsource,
  output logic [DATA_W-1:0]     p_alu_r,
  output logic [REG_AW-1:0]     p_rf_waddr,
  output logic [DATA_W-1:0]     p_jalra,
  output logic [DATA_W-1:0]     p_dout,
  output logic                  p_berr
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [DATA_W-1:0]   hold_data;
  logic                hold_berr;

  logic                is_ld, is_st, acc, misalign, mis, fwd;
  logic                timeout_hit, done, abort, adv;
  logic [OFS_W-1:0]    ofs;
  logic [DATA_W-1:0]   sd, ld_val, nxt_dout;
  logic                nxt_berr;

  // Byte-enable pattern for an access of 2^size bytes at lane offset ofs.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                 input logic [OFS_W-1:0] o);
    int nb;
    nb = 1 << size;
    if (nb > LANES) nb = LANES;
    return (~({LANES{1'b1}} << nb)) << o;
  endfunction

  // Repeat the low 2^size bytes of d across every byte lane.
  function automatic logic [DATA_W-1:0] lane_replicate(input logic [DATA_W-1:0] d,
                                                       input logic [1:0] size);
    logic [DATA_W-1:0] r;
    int nb;
    nb = 1 << size;
    if (nb > LANES) nb = LANES;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*8 +: 8] = d[(i % nb)*8 +: 8];
    return r;
  endfunction

  // Right-align the addressed bytes, then zero- or sign-extend them.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] d,
                                                     input logic [OFS_W-1:0] o,
                                                     input logic [1:0] size,
                                                     input logic sext);
    logic [DATA_W-1:0] sh, mask, msb, r;
    int nbits;
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    sh   = d >> {o, 3'b000};
    mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
    msb  = mask & ~(mask >> 1);
    r    = sh & mask;
    if (sext && ((sh & msb) != '0)) r = r | ~mask;
    return r;
  endfunction

  always_comb begin
    misalign = 1'b0;
    case (ex_c_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ex_alu_r[0];
      2'b10:   misalign = |ex_alu_r[1:0];
      default: misalign = (DATA_W == 32) ? 1'b1 : |ex_alu_r[2:0];
    endcase
  end

  assign is_ld = (ex_c_drw == 2'b10);
  assign is_st = (ex_c_drw == 2'b01);
  assign acc   = is_ld | is_st;
  assign mis   = acc & misalign;
  assign ofs   = ex_alu_r[OFS_W-1:0];

  // Store data bypass from WB when the previous instruction writes ex_rt.
  assign fwd = p_c_rfw & (ex_rt == p_rf_waddr) & (p_rf_waddr != '0);
  assign sd  = fwd ? wb_wdata : ex_rfb;

  // Bus request stage
  assign dmem_addr = {ex_alu_r[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
  assign dmem_we   = is_st;
  assign dmem_be   = lane_mask(ex_c_size, ofs);
  assign dmem_data = lane_replicate(sd, ex_c_size);
  assign dmem_req  = ((state == IDLE) & acc & ~mis) | (state == BUSY);

  assign timeout_hit = (state == BUSY) & (wait_cnt == CNT_W'(TIMEOUT));
  assign done        = dmem_req & dmem_ack;
  assign abort       = timeout_hit & ~dmem_ack;
  assign mem_stall   = dmem_req & ~dmem_ack & ~timeout_hit;
  assign adv         = ~cpu_stall & ~mem_stall;

  // Stores and aborted accesses return zero data.
  assign ld_val   = (is_ld & done) ? load_extract(dmem_in, ofs, ex_c_size, ex_c_sext) : '0;
  assign nxt_dout = (state == HOLD) ? hold_data : ld_val;
  assign nxt_berr = (state == HOLD) ? hold_berr : (mis | abort);

  // The counter already reads 1 on entering BUSY, so TIMEOUT counts every
  // stalled cycle including the initial IDLE one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      hold_data <= '0;
      hold_berr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dmem_req) begin
            if (dmem_ack) begin
              hold_data <= ld_val;
              hold_berr <= 1'b0;
              state     <= cpu_stall ? HOLD : IDLE;
            end else begin
              wait_cnt <= CNT_W'(1);
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            hold_data <= ld_val;
            hold_berr <= 1'b0;
            wait_cnt  <= '0;
            state     <= cpu_stall ? HOLD : IDLE;
          end else if (timeout_hit) begin
            hold_data <= '0;
            hold_berr <= 1'b1;
            wait_cnt  <= '0;
            state     <= cpu_stall ? HOLD : IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!cpu_stall) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB pipeline register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_c_rfw      <= 1'b0;
      p_c_wbsource <= '0;
      p_alu_r      <= '0;
      p_rf_waddr   <= '0;
      p_jalra      <= '0;
      p_dout       <= '0;
      p_berr       <= 1'b0;
    end else if (adv) begin
      p_c_rfw      <= ex_c_rfw & ~nxt_berr;
      p_c_wbsource <= ex_c_wbsource;
      p_alu_r      <= ex_alu_r;
      p_rf_waddr   <= ex_rf_waddr;
      p_jalra      <= ex_jalra;
      p_dout       <= nxt_dout;
      p_berr       <= nxt_berr;
    end
  end

endmodule

// File: tb/tb_cpu_mem_lsu.sv
// Bench for cpu_mem_lsu (DATA_W=32, TIMEOUT=4): directed scenarios with literal
// expectations, then randomized CPU-like traffic checked every cycle against
// a transaction-level model of the unit.
module tb_cpu_mem_lsu;
  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int TO  = 4;

  logic            clk = 1'b0;
  logic            rst, cpu_stall;
  logic            ex_c_rfw, ex_c_sext;
  logic [1:0]      ex_c_wbsource, ex_c_drw, ex_c_size;
  logic [DW-1:0]   ex_alu_r, ex_rfb, ex_jalra, wb_wdata, dmem_in;
  logic [RAW-1:0]  ex_rf_waddr, ex_rt;
  logic            dmem_ack;
  logic            dmem_req, dmem_we, mem_stall, p_c_rfw, p_berr;
  logic [DW-1:0]   dmem_addr, dmem_data, p_alu_r, p_jalra, p_dout;
  logic [DW/8-1:0] dmem_be;
  logic [1:0]      p_c_wbsource;
  logic [RAW-1:0]  p_rf_waddr;

  always #5 clk = ~clk;

  cpu_mem_lsu #(.DATA_W(DW), .REG_AW(RAW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall),
    .ex_c_rfw(ex_c_rfw), .ex_c_wbsource(ex_c_wbsource), .ex_c_drw(ex_c_drw),
    .ex_c_size(ex_c_size), .ex_c_sext(ex_c_sext),
    .ex_alu_r(ex_alu_r), .ex_rfb(ex_rfb), .ex_rf_waddr(ex_rf_waddr), .ex_rt(ex_rt),
    .ex_jalra(ex_jalra), .wb_wdata(wb_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_data(dmem_data), .dmem_in(dmem_in), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource),
    .p_alu_r(p_alu_r), .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra),
    .p_dout(p_dout), .p_berr(p_berr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result: addressed bytes right-aligned, truncated, then extended.
  function automatic logic [31:0] ld_extract(input logic [31:0] d, input int o,
                                             input logic [1:0] size, input logic sext);
    longint v;
    int bits;
    bits = (size >= 2) ? 32 : (8 << size);
    v = longint'(d >> (8 * o));
    v = v % (longint'(1) << bits);
    if (sext && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // Model state: outstanding-access bookkeeping plus the expected pipeline registers.
  int          m_waited;
  logic        m_held, m_hberr, m_adv;
  logic [31:0] m_hdout;
  logic        m_p_rfw, m_p_berr;
  logic [1:0]  m_p_wbs;
  logic [31:0] m_p_alu, m_p_jalra, m_p_dout;
  logic [4:0]  m_p_waddr;

  int          n_waited;
  logic        n_held, n_hberr;
  logic [31:0] n_hdout;
  logic        n_p_rfw, n_p_berr;
  logic [1:0]  n_p_wbs;
  logic [31:0] n_p_alu, n_p_jalra, n_p_dout;
  logic [4:0]  n_p_waddr;

  int          nb, ofs;
  logic        c_ld, c_acc, c_mis, c_fwd, c_req, c_abort, c_done, c_stall, c_berr;
  logic [31:0] c_sd, c_data, c_res;
  logic [3:0]  c_be;

  task automatic model_reset();
    m_waited = 0; m_held = 0; m_hberr = 0; m_hdout = 0; m_adv = 0;
    m_p_rfw = 0; m_p_berr = 0; m_p_wbs = 0; m_p_alu = 0; m_p_jalra = 0;
    m_p_dout = 0; m_p_waddr = 0;
  endtask

  initial model_reset();

  always begin
    @(negedge clk);
    #2;
    if (rst) model_reset();
    c_ld   = (ex_c_drw == 2'b10);
    c_acc  = c_ld || (ex_c_drw == 2'b01);
    nb     = 1 << ex_c_size;
    ofs    = int'(ex_alu_r[1:0]);
    c_mis  = c_acc && (ex_c_size == 2'b11 || (int'(ex_alu_r[2:0]) % nb) != 0);
    c_fwd  = m_p_rfw && (ex_rt == m_p_waddr) && (m_p_waddr != 0);
    c_sd   = c_fwd ? wb_wdata : ex_rfb;
    case (ex_c_size)
      2'b00:   c_data = {24'd0, c_sd[7:0]} * 32'h0101_0101;
      2'b01:   c_data = {16'd0, c_sd[15:0]} * 32'h0001_0001;
      default: c_data = c_sd;
    endcase
    c_be    = 4'(((1 << nb) - 1) << ofs);
    c_req   = !m_held && c_acc && !c_mis;
    c_abort = c_req && !dmem_ack && (m_waited == TO);
    c_done  = c_req && dmem_ack;
    c_stall = c_req && !dmem_ack && !c_abort;
    c_res   = (c_done && c_ld) ? ld_extract(dmem_in, ofs, ex_c_size, ex_c_sext) : 32'd0;
    m_adv   = !cpu_stall && !c_stall;

    chk("dmem_req", 32'(dmem_req), 32'(c_req));
    chk("dmem_we", 32'(dmem_we), 32'(ex_c_drw == 2'b01));
    chk("dmem_addr", dmem_addr, ex_alu_r & 32'hFFFF_FFFC);
    chk("dmem_be", 32'(dmem_be), 32'(c_be));
    chk("dmem_data", dmem_data, c_data);
    chk("mem_stall", 32'(mem_stall), 32'(c_stall));

    n_waited = m_waited; n_held = m_held; n_hberr = m_hberr; n_hdout = m_hdout;
    if (m_held) begin
      if (!cpu_stall) n_held = 0;
    end else if (c_req) begin
      if (c_done || c_abort) begin
        n_waited = 0;
        if (cpu_stall) begin
          n_held = 1; n_hdout = c_res; n_hberr = c_abort;
        end
      end else begin
        n_waited = m_waited + 1;
      end
    end
    n_p_rfw = m_p_rfw; n_p_berr = m_p_berr; n_p_wbs = m_p_wbs; n_p_alu = m_p_alu;
    n_p_jalra = m_p_jalra; n_p_dout = m_p_dout; n_p_waddr = m_p_waddr;
    if (m_adv) begin
      c_berr    = m_held ? m_hberr : (c_mis || c_abort);
      n_p_berr  = c_berr;
      n_p_dout  = m_held ? m_hdout : c_res;
      n_p_rfw   = ex_c_rfw && !c_berr;
      n_p_wbs   = ex_c_wbsource;
      n_p_alu   = ex_alu_r;
      n_p_jalra = ex_jalra;
      n_p_waddr = ex_rf_waddr;
    end

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_waited = n_waited; m_held = n_held; m_hberr = n_hberr; m_hdout = n_hdout;
      m_p_rfw = n_p_rfw; m_p_berr = n_p_berr; m_p_wbs = n_p_wbs; m_p_alu = n_p_alu;
      m_p_jalra = n_p_jalra; m_p_dout = n_p_dout; m_p_waddr = n_p_waddr;
    end
    chk("p_c_rfw", 32'(p_c_rfw), 32'(m_p_rfw));
    chk("p_c_wbsource", 32'(p_c_wbsource), 32'(m_p_wbs));
    chk("p_alu_r", p_alu_r, m_p_alu);
    chk("p_rf_waddr", 32'(p_rf_waddr), 32'(m_p_waddr));
    chk("p_jalra", p_jalra, m_p_jalra);
    chk("p_dout", p_dout, m_p_dout);
    chk("p_berr", 32'(p_berr), 32'(m_p_berr));
  end

  task automatic set_ex(input logic [1:0] drw, input logic [1:0] size, input logic sext,
                        input logic rfw, input logic [31:0] addr, input logic [31:0] rfb,
                        input logic [4:0] rt, input logic [4:0] waddr);
    ex_c_drw = drw; ex_c_size = size; ex_c_sext = sext; ex_c_rfw = rfw;
    ex_alu_r = addr; ex_rfb = rfb; ex_rt = rt; ex_rf_waddr = waddr;
    ex_c_wbsource = 2'(waddr); ex_jalra = addr ^ 32'h5A5A_0000;
  endtask

  logic        fresh;
  logic [31:0] a;

  initial begin
    rst = 1'b1; cpu_stall = 1'b0; dmem_ack = 1'b0; dmem_in = '0; wb_wdata = '0;
    set_ex(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    #3;
    chk("rst p_dout", p_dout, 32'h0);
    chk("rst p_berr", 32'(p_berr), 32'h0);
    chk("rst p_c_rfw", 32'(p_c_rfw), 32'h0);
    chk("rst dmem_req", 32'(dmem_req), 32'h0);
    chk("rst mem_stall", 32'(mem_stall), 32'h0);

    // Zero-wait signed byte load from the top lane.
    @(negedge clk);
    rst = 1'b0;
    set_ex(2'b10, 2'b00, 1'b1, 1'b1, 32'h103, 32'h0, 5'd0, 5'd1);
    dmem_in = 32'h80AA_BBCC; dmem_ack = 1'b1;
    #3;
    chk("lb be", 32'(dmem_be), 32'h8);
    chk("lb req", 32'(dmem_req), 32'h1);
    chk("lb stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    chk("lb p_dout", p_dout, 32'hFFFF_FF80);
    chk("lb p_c_rfw", 32'(p_c_rfw), 32'h1);

    // Half store acked after three wait cycles.
    set_ex(2'b01, 2'b01, 1'b0, 1'b1, 32'h202, 32'h1234_ABCD, 5'd9, 5'd3);
    dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("sh stall", 32'(mem_stall), 32'h1);
      if (k == 0) begin
        chk("sh be", 32'(dmem_be), 32'hC);
        chk("sh data", dmem_data, 32'hABCD_ABCD);
      end
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    #3;
    chk("sh ack stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    chk("sh p_c_rfw", 32'(p_c_rfw), 32'h1);
    chk("sh p_dout", p_dout, 32'h0);

    // Misaligned word load: no bus request, error in one cycle.
    set_ex(2'b10, 2'b10, 1'b0, 1'b1, 32'h101, 32'h0, 5'd0, 5'd5);
    dmem_ack = 1'b0;
    #3;
    chk("mis req", 32'(dmem_req), 32'h0);
    chk("mis stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    chk("mis p_berr", 32'(p_berr), 32'h1);
    chk("mis p_c_rfw", 32'(p_c_rfw), 32'h0);

    // No ack at all: four stall cycles, then abort.
    set_ex(2'b10, 2'b10, 1'b0, 1'b1, 32'h100, 32'h0, 5'd0, 5'd6);
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("to stall", 32'(mem_stall), 32'h1);
      @(negedge clk);
    end
    #3;
    chk("to release", 32'(mem_stall), 32'h0);
    @(negedge clk);
    chk("to p_berr", 32'(p_berr), 32'h1);
    chk("to p_c_rfw", 32'(p_c_rfw), 32'h0);
    set_ex(2'b10, 2'b10, 1'b0, 1'b1, 32'h104, 32'h0, 5'd0, 5'd6);
    dmem_in = 32'hCAFE_F00D; dmem_ack = 1'b1;
    #3;
    chk("post-to req", 32'(dmem_req), 32'h1);
    chk("post-to stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    chk("post-to p_dout", p_dout, 32'hCAFE_F00D);
    chk("post-to p_berr", 32'(p_berr), 32'h0);

    // Ack under a two-cycle CPU stall: result held across changing dmem_in.
    set_ex(2'b10, 2'b10, 1'b0, 1'b1, 32'h204, 32'h0, 5'd0, 5'd2);
    dmem_in = 32'h1122_3344; dmem_ack = 1'b1; cpu_stall = 1'b1;
    #3;
    chk("hold req0", 32'(dmem_req), 32'h1);
    @(negedge clk);
    dmem_in = 32'h5566_7788; dmem_ack = 1'b0;
    #3;
    chk("hold req1", 32'(dmem_req), 32'h0);
    chk("hold stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    cpu_stall = 1'b0;
    #3;
    chk("hold req2", 32'(dmem_req), 32'h0);
    @(negedge clk);
    chk("hold p_dout", p_dout, 32'h1122_3344);

    // Store-data forwarding from WB, and no forwarding through r0.
    set_ex(2'b00, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd7);
    @(negedge clk);
    set_ex(2'b01, 2'b10, 1'b0, 1'b0, 32'h300, 32'h0102_0304, 5'd7, 5'd0);
    wb_wdata = 32'hDEAD_BEEF; dmem_ack = 1'b1;
    #3;
    chk("fwd data", dmem_data, 32'hDEAD_BEEF);
    @(negedge clk);
    set_ex(2'b00, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0);
    dmem_ack = 1'b0;
    @(negedge clk);
    set_ex(2'b01, 2'b10, 1'b0, 1'b0, 32'h300, 32'h0102_0304, 5'd0, 5'd0);
    dmem_ack = 1'b1;
    #3;
    chk("r0 data", dmem_data, 32'h0102_0304);
    @(negedge clk);
    set_ex(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    dmem_ack = 1'b0;

    // Randomized traffic; EX only moves on once the model says the pipe advanced.
    fresh = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        fresh = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
      end
      if (fresh || m_adv) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        set_ex(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
        fresh = 1'b0;
      end
      cpu_stall = ($urandom_range(0, 3) == 0);
      dmem_ack  = ($urandom_range(0, 2) == 0);
      dmem_in   = $urandom;
      wb_wdata  = $urandom;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_lsu.md
CPU_MEM_LSU -- requirements
Module: cpu_mem_lsu

Interface
REQ-001 Parameter DATA_W, default 32, is the data bus width; legal values are 32 or 64; LANES = DATA_W/8 and OFS_W = log2(LANES).
REQ-002 Parameter REG_AW, default 5, is the register-file address width.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of wait cycles before an access aborts; legal range is 1..1023.
REQ-004 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  is the reset, asynchronous and active-high.
REQ-006 cpu_stall  in  1  is the global pipeline freeze.
REQ-007 ex_c_rfw in 1, ex_c_wbsource in 2, ex_c_drw in 2, ex_c_size in 2, ex_c_sext in 1 are the EX-stage controls:
- ex_c_drw: 10 = load, 01 = store, 00/11 = none.
- ex_c_size: 00 = byte, 01 = half, 10 = word, 11 = double (DATA_W=64 only).
REQ-008 The EX-stage data inputs are:
- ex_alu_r in DATA_W (address)
- ex_rfb in DATA_W (store data)
- ex_rf_waddr in REG_AW
- ex_rt in REG_AW
- ex_jalra in DATA_W
- wb_wdata in DATA_W (WB forwarding value)
REQ-009 The memory bus is:
- dmem_req out 1, dmem_we out 1
- dmem_addr out DATA_W
- dmem_be out LANES
- dmem_data out DATA_W
- dmem_in in DATA_W
- dmem_ack in 1
REQ-010 The outputs are:
- mem_stall out 1
- p_c_rfw out 1, p_c_wbsource out 2
- p_alu_r out DATA_W, p_rf_waddr out REG_AW, p_jalra out DATA_W
- p_dout out DATA_W, p_berr out 1

Function
REQ-011 acc = (ex_c_drw==10 or 01); mis = acc and the address is not size-aligned (half: a[0]; word: a[1:0]; double: a[2:0]); size 11 when DATA_W=32 also sets mis.
REQ-012 fwd = p_c_rfw & (ex_rt==p_rf_waddr) & (p_rf_waddr!=0); sd = fwd ? wb_wdata : ex_rfb.
REQ-013 Bus outputs:
- dmem_addr = ex_alu_r with its low OFS_W bits cleared.
- dmem_we = (ex_c_drw==01).
- dmem_be = the size mask (1, 3, F or FF) shifted left by ex_alu_r[OFS_W-1:0].
- dmem_data = the low 2^size bytes of sd replicated across all lanes.
REQ-014 The FSM states are IDLE, BUSY and HOLD; dmem_req = (IDLE & acc & !mis) | BUSY, and dmem_req is 0 in HOLD.
REQ-015 IDLE transitions on request:
- dmem_ack=1 in the same cycle is a zero-wait completion; the next state is HOLD if cpu_stall=1, else IDLE.
- No ack moves to BUSY.
REQ-016 BUSY transitions:
- dmem_ack=1 completes the access; the next state is HOLD if cpu_stall=1, else IDLE.
- Otherwise the wait counter increments; when it reaches TIMEOUT without an ack, the access aborts with berr and the next state is IDLE (or HOLD if cpu_stall=1).
REQ-017 The wait counter clears on every entry to IDLE.
REQ-018 On completion, the load result is captured into a hold register:
- dmem_in is shifted right by offset*8 and truncated to 2^size bytes.
- It is sign-extended if ex_c_sext=1, else zero-extended.
- Store completions capture 0.
REQ-019 HOLD keeps the hold register and berr flag and issues no request; it exits to IDLE on the first cycle with cpu_stall=0, and the pipeline registers advance in that cycle.
REQ-020 mem_stall = dmem_req & !dmem_ack & !(BUSY & counter==TIMEOUT).
REQ-021 Pipeline registers advance when adv = !cpu_stall & !mem_stall; otherwise all p_* outputs hold.
REQ-022 On adv, p_c_wbsource, p_alu_r, p_rf_waddr and p_jalra load their ex_* values.
REQ-023 On adv, p_dout loads the extracted load value (from the hold register if leaving HOLD, else from the current dmem_in).
REQ-024 On adv, p_berr = mis | abort, and p_c_rfw = ex_c_rfw & !p_berr-next.
REQ-025 With acc=0, adv depends only on cpu_stall; p_dout loads 0 and p_berr loads 0.
REQ-026 A misaligned access issues no bus request, completes in one cycle, and sets p_berr=1.

Reset
REQ-027 When rst=1, asynchronously:
- state = IDLE; wait counter and hold register = 0.
- p_c_rfw, p_c_wbsource, p_alu_r, p_rf_waddr, p_jalra, p_dout and p_berr = 0.
- dmem_req and mem_stall evaluate from IDLE.
REQ-028 Reset asserted mid-BUSY abandons the access without an error; the bus agent is responsible for discarding any late ack.
REQ-029 The first request after rst deasserts may issue in the next cycle.

Verification
REQ-030 DATA_W=32: load byte, addr 0x103, sext=1, dmem_in 0x80AABBCC, zero-wait ack -> dmem_be=1000, p_dout=0xFFFFFF80 one cycle later, mem_stall never 1.
REQ-031 Store half, addr 0x202, ex_rfb 0x1234ABCD, ack after 3 cycles -> dmem_be=1100, dmem_data=0xABCDABCD, mem_stall=1 for exactly 3 cycles, p_c_rfw follows ex_c_rfw.
REQ-032 Load word, addr 0x101 -> dmem_req stays 0, p_berr=1, p_c_rfw=0 after one cycle.
REQ-033 TIMEOUT=4, load with ack held at 0 -> mem_stall=1 for 4 cycles, then p_berr=1, p_c_rfw=0, state IDLE.
REQ-034 Ack arrives while cpu_stall=1 for 2 cycles -> state HOLD, dmem_req=0; on stall release p_dout equals the captured data even though dmem_in has changed.
REQ-035 Store with ex_rt=p_rf_waddr=7, p_c_rfw=1, wb_wdata=0xDEADBEEF, word size -> dmem_data=0xDEADBEEF; same case with p_rf_waddr=0 -> dmem_data=ex_rfb.
